// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory-port arbiter.
// Arbiter FSM states and requester identities.
// No timing or flow-control content; type and constant definitions only.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick between the CPU and loader requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_id,
    output logic gnt_vld
);

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_id  = REQ_CPU;
        if (req0 && req1) begin
            // on a tie the side that did not win last time goes first
            gnt_id = ~last;
        end else if (req1) begin
            gnt_id = REQ_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences the shared MIPS instruction/data memory port between CPU and loader.
// Latency: request sampled in IDLE at cycle k is acked at cycle k+2+MEM_LATENCY.
// Backpressure: requesters hold req and payload until their one-cycle ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N           = 32,
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [N-1:0]      cpu_wdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [N-1:0]      ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_ack,
    output logic [N-1:0]      rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    input  logic [N-1:0]      mem_rdata,
    output logic              owner,
    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic             last_q;
    logic             gnt_id;
    logic             gnt_vld;
    logic             wait_last;

    // ldr_lock masks the CPU out of arbitration entirely
    rr_pick2 u_pick (
        .req0    (cpu_req & ~ldr_lock),
        .req1    (ldr_req),
        .last    (last_q),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    assign wait_last = (state == ARB_WAIT) && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (gnt_vld) state_nxt = ARB_ACCESS;
            ARB_ACCESS: state_nxt = ARB_WAIT;
            ARB_WAIT:   if (wait_last) state_nxt = ARB_RESP;
            ARB_RESP:   state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            we_q      <= 1'b0;
            last_q    <= REQ_LDR;
            owner     <= REQ_CPU;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (gnt_vld) begin
                        owner     <= gnt_id;
                        last_q    <= gnt_id;
                        we_q      <= (gnt_id == REQ_LDR) ? ldr_we    : cpu_we;
                        mem_addr  <= (gnt_id == REQ_LDR) ? ldr_addr  : cpu_addr;
                        mem_wdata <= (gnt_id == REQ_LDR) ? ldr_wdata : cpu_wdata;
                    end
                end
                ARB_ACCESS: cnt <= CNT_W'(MEM_LATENCY);
                ARB_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (wait_last && !we_q) begin
                        rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // strobes and acks are gated by rst so a reset cycle never commits or completes
    assign mem_en  = (state == ARB_ACCESS) && !rst;
    assign mem_we  = (state == ARB_ACCESS) && we_q && !rst;
    assign cpu_ack = (state == ARB_RESP) && (owner == REQ_CPU) && !rst;
    assign ldr_ack = (state == ARB_RESP) && (owner == REQ_LDR) && !rst;
    assign busy    = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0, ldr_lock = 0;
    logic [9:0]  cpu_addr = 0, ldr_addr = 0;
    logic [31:0] cpu_wdata = 0, ldr_wdata = 0, mem_rdata = 0;
    logic        cpu_ack, ldr_ack, mem_en, mem_we, owner, busy;
    logic [31:0] rdata, mem_wdata;
    logic [9:0]  mem_addr;

    logic        c2_req = 0;
    logic [9:0]  c2_addr = 0;
    logic [31:0] c2_wdata = 0, m2_rdata = 0;
    logic        c2_ack, l2_ack, m2_en, m2_we, owner2, busy2;
    logic [31:0] rdata2, m2_wdata;
    logic [9:0]  m2_addr;

    int n_checks = 0;
    int n_fail   = 0;

    int          en_cnt, we_cnt;
    logic        both_ack;
    logic [9:0]  seen_addr;
    logic [31:0] seen_wdata;
    int          dt;
    logic        was_cpu;

    mem_port_arbiter #(.N(32), .ADDR_W(10), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_ack(ldr_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    mem_port_arbiter #(.N(32), .ADDR_W(10), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(c2_req), .cpu_we(1'b0), .cpu_addr(c2_addr), .cpu_wdata(c2_wdata),
        .cpu_ack(c2_ack),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(10'd0), .ldr_wdata(32'd0),
        .ldr_lock(1'b0), .ldr_ack(l2_ack),
        .rdata(rdata2), .mem_en(m2_en), .mem_we(m2_we), .mem_addr(m2_addr),
        .mem_wdata(m2_wdata), .mem_rdata(m2_rdata), .owner(owner2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ticks until either ack appears (bounded); dt=99 marks a timeout
    task automatic next_ack(output int d, output logic c);
        d = 99; c = 1'b0;
        en_cnt = 0; we_cnt = 0; both_ack = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (mem_en) begin
                en_cnt++;
                if (mem_we) we_cnt++;
                seen_addr  = mem_addr;
                seen_wdata = mem_wdata;
            end
            if (cpu_ack || ldr_ack) begin
                d = t;
                c = cpu_ack;
                both_ack = cpu_ack && ldr_ack;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_t;
        int en2;
        logic l2_seen, we2_seen;
        logic [9:0]  a2;
        logic [31:0] d2;

        tick(); tick();
        rst = 1'b0;
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_ldr_ack", ldr_ack, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_owner", owner, 0);

        // CPU read
        mem_rdata = 32'h8C22_0000;
        cpu_addr = 10'h004; cpu_we = 0; cpu_req = 1;
        next_ack(dt, was_cpu);
        cpu_req = 0;
        chk("rd_latency", dt, 3);
        chk("rd_is_cpu", was_cpu, 1);
        chk("rd_single_ack", both_ack, 0);
        chk("rd_en_cycles", en_cnt, 1);
        chk("rd_we_cycles", we_cnt, 0);
        chk("rd_addr", seen_addr, 10'h004);
        chk("rd_rdata", rdata, 32'h8C22_0000);
        tick();

        // loader write; rdata must survive
        mem_rdata = 32'h1111_1111;
        ldr_addr = 10'h010; ldr_wdata = 32'hDEAD_BEEF; ldr_we = 1; ldr_req = 1;
        next_ack(dt, was_cpu);
        ldr_req = 0; ldr_we = 0;
        chk("wr_latency", dt, 3);
        chk("wr_is_ldr", was_cpu, 0);
        chk("wr_single_ack", both_ack, 0);
        chk("wr_en_cycles", en_cnt, 1);
        chk("wr_we_cycles", we_cnt, 1);
        chk("wr_addr", seen_addr, 10'h010);
        chk("wr_wdata", seen_wdata, 32'hDEAD_BEEF);
        chk("wr_rdata_kept", rdata, 32'h8C22_0000);
        tick();

        // both requesting continuously from reset: CPU wins first tie
        rst = 1; tick();
        rst = 0; cpu_req = 1; ldr_req = 1; cpu_addr = 10'h100; ldr_addr = 10'h200;
        mem_rdata = 32'h3333_0000;
        for (int i = 0; i < 4; i++) begin
            next_ack(dt, was_cpu);
            chk($sformatf("rr_gap%0d", i), dt, (i == 0) ? 3 : 4);
            chk($sformatf("rr_owner%0d", i), was_cpu, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_single%0d", i), both_ack, 0);
        end
        cpu_req = 0; ldr_req = 0;
        tick(); tick();

        // lock with no loader request keeps the port idle
        ldr_lock = 1; cpu_req = 1;
        tick(); tick();
        chk("lock_idle_busy", busy, 0);
        ldr_req = 1;
        for (int i = 0; i < 3; i++) begin
            next_ack(dt, was_cpu);
            chk($sformatf("lock_gap%0d", i), dt, (i == 0) ? 3 : 4);
            chk($sformatf("lock_ldr%0d", i), was_cpu, 0);
        end
        ldr_lock = 0;
        next_ack(dt, was_cpu);
        chk("unlock_gap", dt, 4);
        chk("unlock_cpu", was_cpu, 1);
        cpu_req = 0; ldr_req = 0;
        tick(); tick();

        // reset during WAIT of a CPU read
        cpu_addr = 10'h020; cpu_wdata = 32'h0000_0055; cpu_we = 0; cpu_req = 1;
        mem_rdata = 32'h4444_4444;
        tick(); tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1; cpu_req = 0;
        tick();
        chk("midrst_cpu_ack", cpu_ack, 0);
        chk("midrst_ldr_ack", ldr_ack, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_mem_wdata", mem_wdata, 0);
        chk("midrst_owner", owner, 0);
        rst = 0; cpu_req = 1; mem_rdata = 32'hCAFE_F00D;
        next_ack(dt, was_cpu);
        cpu_req = 0;
        chk("postrst_latency", dt, 3);
        chk("postrst_cpu", was_cpu, 1);
        chk("postrst_rdata", rdata, 32'hCAFE_F00D);
        tick();

        // write in ACCESS coinciding with reset is not strobed
        ldr_addr = 10'h3FF; ldr_wdata = 32'h0BAD_0BAD; ldr_we = 1; ldr_req = 1;
        tick();
        chk("acc_we_pre", mem_we, 1);
        rst = 1; ldr_req = 0; ldr_we = 0;
        #1;
        chk("acc_we_rst", mem_we, 0);
        chk("acc_en_rst", mem_en, 0);
        tick();
        rst = 0;
        tick();

        // MEM_LATENCY=3 instance: ack at k+5, only the last WAIT cycle's data captured
        c2_addr = 10'h2A4; c2_wdata = 32'h0000_0077; c2_req = 1;
        m2_rdata = 32'hBAD0_0000;
        ack_t = 99; en2 = 0; l2_seen = 0; we2_seen = 0; a2 = '0; d2 = '0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (m2_en) begin
                en2++;
                a2 = m2_addr;
                d2 = m2_wdata;
                if (m2_we) we2_seen = 1;
            end
            if (l2_ack) l2_seen = 1;
            if (c2_ack && ack_t == 99) begin
                ack_t = t;
                c2_req = 0;
            end
            m2_rdata = (t == 4) ? 32'h600D_DA7A : (32'hBAD0_0000 | t);
        end
        chk("l3_ack_time", ack_t, 5);
        chk("l3_rdata", rdata2, 32'h600D_DA7A);
        chk("l3_en_cycles", en2, 1);
        chk("l3_we", we2_seen, 0);
        chk("l3_addr", a2, 10'h2A4);
        chk("l3_wdata", d2, 32'h0000_0077);
        chk("l3_ldr_ack", l2_seen, 0);
        chk("l3_owner", owner2, 0);
        chk("l3_idle", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
